// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: writeback requester bundle and registered regfile write port
interface wb_arbiter_if #(parameter int NREQ = 2, parameter int XLEN = 64);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_wb_en;
    logic [5*NREQ-1:0]    req_dst;
    logic [XLEN*NREQ-1:0] req_result;
    logic [XLEN*NREQ-1:0] req_pc;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [XLEN-1:0]      rf_wdata;
    logic [XLEN-1:0]      rf_wpc;
    logic [31:0]          conflict_cnt;
    modport master(output req_valid, req_wb_en, req_dst, req_result, req_pc,
                   input req_ready, rf_we, rf_waddr, rf_wdata, rf_wpc, conflict_cnt);
    modport slave(input req_valid, req_wb_en, req_dst, req_result, req_pc,
                  output req_ready, rf_we, rf_waddr, rf_wdata, rf_wpc, conflict_cnt);
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the regfile write port among NREQ pipes, highest index first,
// with age counters that force a grant to any requester starved for STARVE_LIMIT cycles
module wb_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = 64,
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic rst_n,
    wb_arbiter_if.slave bus
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    logic [3:0] age [NREQ];
    logic [NREQ-1:0] wreq, starved, gnt;
    logic g_any;
    logic [IW-1:0] g_idx;
    logic [4:0] g_dst;
    logic [31:0] cnt;
    always_comb begin
        wreq = bus.req_valid & bus.req_wb_en;
        g_any = |wreq;
        g_idx = '0;
        for (int i = 0; i < NREQ; i++) starved[i] = wreq[i] && age[i] >= LIM;
        for (int i = 0; i < NREQ; i++) if (wreq[i]) g_idx = IW'(i);
        // starvation overrides priority; the lowest starved index is scanned last so it wins
        for (int i = NREQ - 1; i >= 0; i--) if (starved[i]) g_idx = IW'(i);
        for (int i = 0; i < NREQ; i++) gnt[i] = g_any && g_idx == IW'(i);
    end
    assign g_dst = bus.req_dst[5*g_idx +: 5];
    assign bus.req_ready = rst_n ? (bus.req_valid & ~bus.req_wb_en) | gnt : '0;
    assign bus.conflict_cnt = cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_we <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.rf_wpc <= '0;
            cnt <= '0;
            for (int i = 0; i < NREQ; i++) age[i] <= '0;
        end else begin
            cnt <= cnt + {31'b0, (wreq & (wreq - NREQ'(1))) != '0};
            for (int i = 0; i < NREQ; i++)
                age[i] <= (gnt[i] || !wreq[i]) ? 4'd0 : (age[i] == LIM ? LIM : age[i] + 4'd1);
            bus.rf_we <= g_any && g_dst != 5'd0;
            if (g_any) begin
                bus.rf_waddr <= g_dst;
                bus.rf_wdata <= bus.req_result[XLEN*g_idx +: XLEN];
                bus.rf_wpc <= bus.req_pc[XLEN*g_idx +: XLEN];
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scenario tasks plus randomized traffic checked against a rule-level model
module tb_wb_arbiter;
    localparam int N = 2, XL = 64, SL = 3;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    wb_arbiter_if #(.NREQ(N), .XLEN(XL)) bus();
    wb_arbiter #(.NREQ(N), .XLEN(XL), .STARVE_LIMIT(SL)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    int total = 0, bad = 0;
    int lost [N];
    logic m_we;
    logic [4:0] m_waddr;
    logic [XL-1:0] m_wdata, m_wpc;
    logic [31:0] m_cnt;

    function automatic bit writes(int i);
        return bus.req_valid[i] && bus.req_wb_en[i];
    endfunction

    // starved writers (lost >= SL) win lowest-first, else highest writer wins
    function automatic int winner();
        int w = -1;
        for (int i = 0; i < N; i++) if (writes(i) && lost[i] >= SL && w < 0) w = i;
        if (w < 0) for (int i = 0; i < N; i++) if (writes(i)) w = i;
        return w;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r = bus.req_valid & ~bus.req_wb_en;
        int w = winner();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) lost[i] = 0;
        m_we = 0; m_waddr = 0; m_wdata = 0; m_wpc = 0; m_cnt = 0;
    endtask

    task automatic m_commit();
        int w = winner();
        int nw = 0;
        for (int i = 0; i < N; i++) begin
            if (writes(i)) begin nw++; lost[i] = (i == w) ? 0 : lost[i] + 1; end
            else lost[i] = 0;
        end
        if (nw >= 2) m_cnt = m_cnt + 1;
        m_we = 0;
        if (w >= 0) begin
            m_waddr = bus.req_dst[5*w +: 5];
            m_we = m_waddr != 0;
            m_wdata = bus.req_result[XL*w +: XL];
            m_wpc = bus.req_pc[XL*w +: XL];
        end
    endtask

    task automatic tick();
        m_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = '0; bus.req_wb_en = '0; bus.req_dst = '0;
        bus.req_result = '0; bus.req_pc = '0;
    endtask

    task automatic set_req(int i, bit v, bit we, logic [4:0] d, logic [XL-1:0] r, logic [XL-1:0] p);
        bus.req_valid[i] = v; bus.req_wb_en[i] = we; bus.req_dst[5*i +: 5] = d;
        bus.req_result[XL*i +: XL] = r; bus.req_pc[XL*i +: XL] = p;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle();
        m_reset();
        set_req(0, 1, 1, 5'd7, 64'h11, 64'h100);
        set_req(1, 1, 1, 5'd9, 64'h22, 64'h200);
        #2;
        total++;
        if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready); end
        rst_n = 1;
        tick();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.conflict_cnt} !== {m_we, m_waddr, m_cnt}) begin
            bad++; $display("FAIL pre_reset_write got=%b/%0d/%0d exp=%b/%0d/%0d",
                            bus.rf_we, bus.rf_waddr, bus.conflict_cnt, m_we, m_waddr, m_cnt);
        end
        #2;
        rst_n = 0;
        #1;
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_wpc, bus.conflict_cnt} !== '0) begin
            bad++; $display("FAIL async_reset_outputs got we=%b a=%0d d=%h pc=%h cnt=%0d exp all zero",
                            bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_wpc, bus.conflict_cnt);
        end
        total++;
        if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready_mid got=%b exp=00", bus.req_ready); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 1, 1, 5'd5, 64'hDEAD_BEEF, 64'h8000_0000);
        #2;
        total++;
        if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", bus.req_ready); end
        tick();
        idle();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_wpc} !== {1'b1, 5'd5, 64'hDEAD_BEEF, 64'h8000_0000}) begin
            bad++; $display("FAIL single_write got=%b/%0d/%h/%h exp=1/5/deadbeef/80000000",
                            bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_wpc);
        end
        #2;
        tick();
        total++;
        if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL single_we_drop got=%b exp=0", bus.rf_we); end
    endtask

    task automatic test_starve();
        logic [N-1:0] exp_seq [8] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_req(0, 1, 1, 5'd1, {$urandom, $urandom}, 64'h1000 + 64'(k));
            set_req(1, 1, 1, 5'd2, {$urandom, $urandom}, 64'h2000 + 64'(k));
            #2;
            total++;
            if (bus.req_ready !== exp_seq[k]) begin
                bad++; $display("FAIL starve_grant[%0d] got=%b exp=%b", k, bus.req_ready, exp_seq[k]);
            end
            tick();
            total++;
            if ({bus.rf_waddr, bus.rf_wdata, bus.rf_wpc} !== {m_waddr, m_wdata, m_wpc}) begin
                bad++; $display("FAIL starve_write[%0d] got=%0d/%h exp=%0d/%h", k, bus.rf_waddr, bus.rf_wdata, m_waddr, m_wdata);
            end
        end
        total++;
        if (bus.conflict_cnt !== 32'd8) begin bad++; $display("FAIL starve_conflicts got=%0d exp=8", bus.conflict_cnt); end
    endtask

    task automatic test_x0_nonwrite();
        do_reset();
        set_req(1, 1, 1, 5'd0, 64'h55, 64'h300);
        #2;
        total++;
        if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL x0_ready got=%b exp=10", bus.req_ready); end
        tick();
        total++;
        if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL x0_we got=%b exp=0", bus.rf_we); end
        set_req(0, 1, 0, 5'd4, 64'h66, 64'h400);
        set_req(1, 1, 1, 5'd3, 64'h77, 64'h500);
        #2;
        total++;
        if (bus.req_ready !== 2'b11) begin bad++; $display("FAIL nonwrite_ready got=%b exp=11", bus.req_ready); end
        tick();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.conflict_cnt} !== {1'b1, 5'd3, 64'h77, 32'd0}) begin
            bad++; $display("FAIL nonwrite_write got=%b/%0d/%h cnt=%0d exp=1/3/77 cnt=0",
                            bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.conflict_cnt);
        end
        idle();
    endtask

    task automatic test_age_reset();
        logic [N-1:0] exp_seq [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            set_req(0, k != 2, 1, 5'd10, 64'(k), 64'h600);
            set_req(1, 1, 1, 5'd11, 64'(k + 100), 64'h700);
            #2;
            total++;
            if (bus.req_ready !== exp_seq[k]) begin
                bad++; $display("FAIL age_reset_grant[%0d] got=%b exp=%b", k, bus.req_ready, exp_seq[k]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_random();
        logic [N-1:0] rdy = '0;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!(bus.req_valid[i] && !rdy[i]))
                    set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 5'($urandom_range(0, 3)),
                            {$urandom, $urandom}, {$urandom, $urandom});
            end
            #2;
            rdy = bus.req_ready;
            total++;
            if (rdy !== m_ready()) begin bad++; $display("FAIL rand_ready[%0d] got=%b exp=%b", k, rdy, m_ready()); end
            tick();
            total++;
            if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_wpc, bus.conflict_cnt} !== {m_we, m_waddr, m_wdata, m_wpc, m_cnt}) begin
                bad++; $display("FAIL rand_write[%0d] got=%b/%0d/%h/%h/%0d exp=%b/%0d/%h/%h/%0d", k,
                                bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_wpc, bus.conflict_cnt,
                                m_we, m_waddr, m_wdata, m_wpc, m_cnt);
            end
        end
        idle();
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cnt;
        m_cnt = 32'hFFFF_FFFF;
        set_req(0, 1, 1, 5'd12, 64'h1, 64'h0);
        set_req(1, 1, 1, 5'd13, 64'h2, 64'h0);
        #1;
        tick();
        total++;
        if (bus.conflict_cnt !== 32'd0 || m_cnt !== 32'd0) begin
            bad++; $display("FAIL cnt_wrap got=%h exp=0", bus.conflict_cnt);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_starve();
        test_x0_nonwrite();
        test_age_reset();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
